spi_channel_arbiter: RTL and testbench
======================================

Name: spi_channel_arbiter

Overview:
- Shares one SPI master (4 chip-select channels, 80-bit shift-out, 32-bit capture, send/ready handshake) between 4 requesters.
- Round-robin arbitration with a per-requester lock so multi-packet bursts are not interleaved.
- Generates the master's single-cycle send pulse, first/last flags and one-hot chip select.
- Returns captured read data with a one-cycle ack per transaction.

Parameters:
- GAP_CYCLES, 2: idle cycles forced between consecutive transactions (0..15).
- BUSY_WAIT, 3: cycles allowed after send for ready to drop before the transaction is aborted.
- TIMEOUT_CYCLES, 1023: watchdog limit for ready to return (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clk in 1: system clock.
- reset in 1: asynchronous, active-high reset.
- req in 4: per-requester transaction request, level, held until ack/err.
- req_last in 4: per-requester; 1 = this transaction ends its burst and releases the lock.
- req_data in 320: requester k data at bits [80k+79:80k], MSB shifted first.
- req_nbytes in 16: requester k byte count at bits [4k+3:4k].
- ack out 4: one-cycle pulse to the granted requester on completion.
- err out 4: one-cycle pulse to the granted requester on reject or abort.
- rdata out 32: read data of the last completed transaction, valid with ack.
- grant out 4: one-hot current owner; 0 when idle and unlocked.
- m_data out 80: to master data_i.
- m_num_bytes out 4: to master num_bytes.
- m_cs out 4: to master cs_i, equals grant.
- m_send out 1: to master send.
- m_first out 1: to master first_packet.
- m_last out 1: to master last_packet.
- m_rdata in 32: from master data_o.
- m_ready in 1: from master ready.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer 3 (requester 0 wins first), lock clear.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND, GAP.
- IDLE, unlocked:
  - Choose the first requester with req=1, searching rr+1, rr+2, ... mod 4; set grant, rr := winner.
  - Latch req_data, req_nbytes and req_last into m_data, m_num_bytes and m_last.
  - m_first := 1, because the requester did not hold the lock.
  - Go to LAUNCH.
- IDLE, locked: only the lock holder is served. Its req=0 leaves the block waiting in IDLE, still locked. m_first := 0.
- Byte-count check in IDLE: if the selected requester's nbytes is 0 or >10, pulse err to it, issue no send, leave the lock unchanged, go to GAP.
- LAUNCH: m_send=1 for exactly one cycle, m_cs=grant; then WAIT_BUSY.
- WAIT_BUSY: m_send=0.
  - m_ready=0 → WAIT_DONE.
  - BUSY_WAIT cycles pass without m_ready=0 → err pulse, lock cleared, go to GAP.
- WAIT_DONE: on m_ready=1, capture m_rdata into rdata and go to RESPOND.
- RESPOND: ack pulse for one cycle to the grant owner.
  - Latched req_last=1 → lock cleared, grant := 0.
  - Otherwise → lock set to the owner.
  - Go to GAP.
- GAP: count GAP_CYCLES, then IDLE. GAP_CYCLES=0 means one pass-through cycle. m_send is guaranteed low for at least 2 cycles between sends.
- Ack timing: 3 + 8·nbytes + GAP-independent cycles from the cycle req is sampled in IDLE to the ack pulse, ±1 cycle of master latency.
- Request changes after latching are ignored until ack/err.
- Dropping req mid-transaction has no effect: the transaction completes and ack is still pulsed.
- Simultaneous requests resolve by round-robin only. Lock beats round-robin.
- Reset mid-transaction: everything returns to reset values immediately. m_send and m_cs drop asynchronously.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined: a 10-bit watchdog counts in WAIT_DONE. Reaching TIMEOUT_CYCLES pulses err, clears the lock and rdata, and goes to GAP. Any later m_ready rise is ignored.
- Undefined: no counter; WAIT_DONE waits indefinitely for m_ready.

Test Plan:
- Single request: req0, nbytes=4, data=0xA5…, master returns 0x12345678 → one m_send pulse, m_cs=0001, m_first=1, ack[0] about 35 cycles later, rdata=0x12345678.
- Contention: req=1111 all held, req_last=1 → grants in order 0,1,2,3,0. Each separated by ≥GAP_CYCLES idle cycles, no double send.
- Burst lock: req1 with req_last=0 then 1 while req2 is held → two req1 transactions back-to-back, m_first=1 then 0, m_last=0 then 1, req2 granted only after.
- Bad length: req3 with nbytes=0, then nbytes=11 → err[3] pulses twice, m_send never asserted, ack stays 0.
- Reset mid-transfer: assert reset during WAIT_DONE → grant, m_cs, m_send, ack all 0 the same cycle; after release, req0 is served first.
- Timeout (SPI_ARB_TIMEOUT_EN): hold m_ready=0 after send → err pulse exactly at TIMEOUT_CYCLES, rdata=0, the next requester is then served.

Source files
------------

// File: rtl/spi_channel_arbiter.sv
// Round-robin arbiter sharing one SPI master between four requesters, with burst lock.
// Optional ready watchdog in WAIT_DONE is built only when SPI_ARB_TIMEOUT_EN is defined.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | pick the lock holder or the next round-robin requester
// LAUNCH      | m_send high for this single cycle
// WAIT_BUSY   | wait for the master to drop ready; abort after BUSY_WAIT
// WAIT_DONE   | wait for ready to return, then capture m_rdata
// RESPOND     | ack pulse visible; lock updated from the latched last flag
// GAP         | forced idle spacing before the next transaction
module spi_channel_arbiter #(
    parameter int GAP_CYCLES     = 2,
    parameter int BUSY_WAIT      = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   req_last,
    input  logic [319:0] req_data,
    input  logic [15:0]  req_nbytes,
    output logic [3:0]   ack,
    output logic [3:0]   err,
    output logic [31:0]  rdata,
    output logic [3:0]   grant,
    output logic [79:0]  m_data,
    output logic [3:0]   m_num_bytes,
    output logic [3:0]   m_cs,
    output logic         m_send,
    output logic         m_first,
    output logic         m_last,
    input  logic [31:0]  m_rdata,
    input  logic         m_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESPOND,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);
    localparam logic [3:0] BUSY_LOAD = 4'(BUSY_WAIT - 1);

    state_t     state;
    logic [1:0] rr;
    logic       locked;
    logic [3:0] gap_cnt;
    logic [3:0] busy_cnt;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [9:0] WD_LOAD = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] wd_cnt;
`endif

    logic [3:0][79:0] data_arr;
    logic [3:0][3:0]  nb_arr;
    assign data_arr = req_data;
    assign nb_arr   = req_nbytes;

    // rr always names the current or most recent owner, so it doubles as the lock holder
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr;
        cand      = rr;
        for (int i = 1; i < 5; i++) begin
            cand = rr + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    logic [1:0] sel_idx;
    logic       sel_valid;
    logic [3:0] sel_nb;
    logic       len_bad;
    assign sel_idx   = locked ? rr : win_idx;
    assign sel_valid = locked ? req[rr] : win_found;
    assign sel_nb    = nb_arr[sel_idx];
    assign len_bad   = (sel_nb == 4'd0) || (sel_nb > 4'd10);

    assign m_cs = grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rr          <= 2'd3;
            locked      <= 1'b0;
            gap_cnt     <= '0;
            busy_cnt    <= '0;
            ack         <= '0;
            err         <= '0;
            rdata       <= '0;
            grant       <= '0;
            m_data      <= '0;
            m_num_bytes <= '0;
            m_send      <= 1'b0;
            m_first     <= 1'b0;
            m_last      <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            ack    <= '0;
            err    <= '0;
            m_send <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        rr <= sel_idx;
                        if (len_bad) begin
                            // rejected length leaves the lock, and hence grant, as it was
                            err     <= 4'b0001 << sel_idx;
                            grant   <= locked ? grant : 4'b0000;
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end else begin
                            grant       <= 4'b0001 << sel_idx;
                            m_data      <= data_arr[sel_idx];
                            m_num_bytes <= sel_nb;
                            m_last      <= req_last[sel_idx];
                            m_first     <= !locked;
                            m_send      <= 1'b1;
                            state       <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    busy_cnt <= BUSY_LOAD;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!m_ready) begin
`ifdef SPI_ARB_TIMEOUT_EN
                        wd_cnt <= WD_LOAD;
`endif
                        state <= S_WAIT_DONE;
                    end else if (busy_cnt == 4'd0) begin
                        err     <= grant;
                        locked  <= 1'b0;
                        grant   <= '0;
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end else begin
                        busy_cnt <= busy_cnt - 4'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (m_ready) begin
                        rdata <= m_rdata;
                        ack   <= grant;
                        state <= S_RESPOND;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (wd_cnt == 10'd0) begin
                        err     <= grant;
                        locked  <= 1'b0;
                        grant   <= '0;
                        rdata   <= '0;
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end else begin
                        wd_cnt <= wd_cnt - 10'd1;
                    end
`endif
                end
                S_RESPOND: begin
                    if (m_last) begin
                        locked <= 1'b0;
                        grant  <= '0;
                    end else begin
                        locked <= 1'b1;
                    end
                    gap_cnt <= GAP_LOAD;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_channel_arbiter.sv
// Directed bench for spi_channel_arbiter with a simple behavioural SPI master.
module tb_spi_channel_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   req_last;
    logic [319:0] req_data;
    logic [15:0]  req_nbytes;
    logic [3:0]   ack;
    logic [3:0]   err;
    logic [31:0]  rdata;
    logic [3:0]   grant;
    logic [79:0]  m_data;
    logic [3:0]   m_num_bytes;
    logic [3:0]   m_cs;
    logic         m_send;
    logic         m_first;
    logic         m_last;
    logic [31:0]  m_rdata;
    logic         m_ready;

    logic [3:0][79:0] dat;
    logic [3:0][3:0]  nb;
    assign req_data   = dat;
    assign req_nbytes = nb;

    always #5 clk = ~clk;

    spi_channel_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_last(req_last),
        .req_data(req_data), .req_nbytes(req_nbytes), .ack(ack), .err(err),
        .rdata(rdata), .grant(grant), .m_data(m_data), .m_num_bytes(m_num_bytes),
        .m_cs(m_cs), .m_send(m_send), .m_first(m_first), .m_last(m_last),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // behavioural master: busy for 8 cycles per byte after each send
    logic        master_on = 1'b1;
    logic        stuck = 1'b0;
    logic [31:0] next_rdata = '0;
    initial begin
        int n;
        m_ready = 1'b1;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (m_send === 1'b1 && master_on) begin
                m_ready = 1'b0;
                n = stuck ? 1100 : 8 * int'(m_num_bytes);
                repeat (n) @(negedge clk);
                m_rdata = next_rdata;
                m_ready = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [3:0]  cs;
        logic        first;
        logic        last;
        logic [79:0] data;
    } send_t;
    send_t send_log[$];
    int    double_send = 0;
    int    min_low = 1000;
    int    low_run = 0;
    logic  prev_send = 1'b0;
    logic  have_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_send === 1'b1) begin
                if (prev_send) double_send++;
                else begin
                    if (have_prev && low_run < min_low) min_low = low_run;
                    send_log.push_back('{m_cs, m_first, m_last, m_data});
                    have_prev = 1'b1;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_send = m_send;
        end
    end

    task automatic wait_resp(input int budget, output int lat, output logic [3:0] a,
                             output logic [3:0] e, output logic [31:0] rd);
        lat = 0; a = '0; e = '0; rd = '0;
        while (lat < budget) begin
            @(negedge clk);
            lat++;
            if ((ack | err) != 4'b0000) begin
                a = ack; e = err; rd = rdata;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        logic [3:0] a, e;
        logic [31:0] rd;
        logic [3:0] exp_oh;

        reset = 1'b1; req = '0; req_last = '0; dat = '0; nb = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 4'b0000);
        check("rst_cs", m_cs, 4'b0000);
        check("rst_send", m_send, 1'b0);
        check("rst_ack_err", {ack, err}, 8'h00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_first_last", {m_first, m_last}, 2'b00);
        reset = 1'b0;
        @(negedge clk);

        // single request
        send_log.delete();
        dat[0] = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
        nb[0] = 4'd4; req_last[0] = 1'b1; next_rdata = 32'h1234_5678;
        req = 4'b0001;
        wait_resp(100, lat, a, e, rd);
        req = 4'b0000;
        check("single_ack", a, 4'b0001);
        check("single_err", e, 4'b0000);
        check("single_rdata", rd, 32'h1234_5678);
        check("single_lat_ok", (lat >= 34 && lat <= 36), 1'b1);
        repeat (5) @(negedge clk);
        check("single_nsend", send_log.size(), 1);
        if (send_log.size() == 1) begin
            check("single_cs", send_log[0].cs, 4'b0001);
            check("single_first", send_log[0].first, 1'b1);
            check("single_last", send_log[0].last, 1'b1);
            check("single_data", send_log[0].data, 80'hA5A5_A5A5_A5A5_A5A5_A5A5);
        end
        check("idle_grant", grant, 4'b0000);

        // contention after reset: order 0,1,2,3,0
        do_reset();
        send_log.delete();
        dat[0] = 80'h1111_1111_1111_1111_1111; dat[1] = 80'h2222_2222_2222_2222_2222;
        dat[2] = 80'h3333_3333_3333_3333_3333; dat[3] = 80'h4444_4444_4444_4444_4444;
        nb = {4'd1, 4'd1, 4'd1, 4'd1};
        req_last = 4'b1111; next_rdata = 32'hC0DE_0001;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_oh = 4'b0001 << (i % 4);
            wait_resp(100, lat, a, e, rd);
            check($sformatf("rr_ack%0d", i), a, exp_oh);
        end
        req = 4'b0000;
        repeat (5) @(negedge clk);
        check("rr_nsend", send_log.size(), 5);
        if (send_log.size() == 5) begin
            check("rr_data1", send_log[1].data, 80'h2222_2222_2222_2222_2222);
            check("rr_cs3", send_log[3].cs, 4'b1000);
            check("rr_cs4", send_log[4].cs, 4'b0001);
        end

        // burst lock: req1 two packets, req2 waits
        send_log.delete();
        nb[1] = 4'd2; nb[2] = 4'd1;
        req_last = 4'b0100;
        req = 4'b0110;
        wait_resp(100, lat, a, e, rd);
        check("lock_ack0", a, 4'b0010);
        req_last[1] = 1'b1;
        @(negedge clk);
        check("lock_grant_held", grant, 4'b0010);
        wait_resp(100, lat, a, e, rd);
        check("lock_ack1", a, 4'b0010);
        req[1] = 1'b0;
        wait_resp(100, lat, a, e, rd);
        check("lock_ack2", a, 4'b0100);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        check("lock_nsend", send_log.size(), 3);
        if (send_log.size() == 3) begin
            check("lock_fl0", {send_log[0].cs, send_log[0].first, send_log[0].last}, 6'b0010_10);
            check("lock_fl1", {send_log[1].cs, send_log[1].first, send_log[1].last}, 6'b0010_01);
            check("lock_fl2", {send_log[2].cs, send_log[2].first, send_log[2].last}, 6'b0100_11);
        end

        // bad lengths on requester 3
        send_log.delete();
        nb[3] = 4'd0; req_last[3] = 1'b1;
        req = 4'b1000;
        wait_resp(50, lat, a, e, rd);
        check("len0_err", e, 4'b1000);
        check("len0_ack", a, 4'b0000);
        check("len0_grant", grant, 4'b0000);
        nb[3] = 4'd11;
        wait_resp(50, lat, a, e, rd);
        check("len11_err", e, 4'b1000);
        check("len11_ack", a, 4'b0000);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        check("len_nsend", send_log.size(), 0);

        // ten bytes is the largest legal length
        nb[0] = 4'd10; req_last[0] = 1'b1; next_rdata = 32'hCAFE_0010;
        req = 4'b0001;
        wait_resp(200, lat, a, e, rd);
        req = 4'b0000;
        check("len10_ack", a, 4'b0001);
        check("len10_rdata", rd, 32'hCAFE_0010);

        // master never goes busy: abort after BUSY_WAIT
        repeat (5) @(negedge clk);
        send_log.delete();
        master_on = 1'b0;
        nb[2] = 4'd2; req_last[2] = 1'b1;
        req = 4'b0100;
        wait_resp(50, lat, a, e, rd);
        req = 4'b0000;
        check("abort_err", e, 4'b0100);
        check("abort_ack", a, 4'b0000);
        check("abort_lat", lat, 5);
        check("abort_grant", grant, 4'b0000);
        check("abort_nsend", send_log.size(), 1);
        master_on = 1'b1;
        repeat (5) @(negedge clk);

        // reset in WAIT_DONE
        nb[0] = 4'd4; req_last[0] = 1'b1;
        req = 4'b0001;
        repeat (10) @(negedge clk);
        check("mid_cs_before", m_cs, 4'b0001);
        reset = 1'b1;
        #1;
        check("mid_rst_outs", {grant, m_cs, m_send, ack}, 13'h0);
        req = 4'b0000;
        repeat (40) @(negedge clk);
        reset = 1'b0;
        nb[0] = 4'd1; nb[2] = 4'd1; req_last = 4'b1111; next_rdata = 32'h0BAD_F00D;
        req = 4'b0101;
        wait_resp(100, lat, a, e, rd);
        check("post_rst_first", a, 4'b0001);
        req[0] = 1'b0;
        wait_resp(100, lat, a, e, rd);
        check("post_rst_second", a, 4'b0100);
        req = 4'b0000;
        repeat (5) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
        stuck = 1'b1; next_rdata = 32'h5555_AAAA;
        nb[0] = 4'd1; nb[1] = 4'd1;
        req = 4'b0011;
        wait_resp(1500, lat, a, e, rd);
        stuck = 1'b0;
        req[0] = 1'b0;
        check("wd_err", e, 4'b0001);
        check("wd_lat", lat, 1026);
        check("wd_rdata", rd, 32'h0);
        wait_resp(300, lat, a, e, rd);
        check("wd_next_ack", a, 4'b0010);
        req = 4'b0000;
        repeat (5) @(negedge clk);
`endif

        check("no_double_send", double_send, 0);
        check("send_spacing_ok", (min_low >= 2), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
